// File: rtl/proc_pkg.sv
// Shared processor definitions: muladd controller state encoding and the
// write-enable mux select values used by the decoder and the mux.
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_AB     = 3'd1,
    MUL_ISSUE = 3'd2,
    MUL_WAIT  = 3'd3,
    ADD_ISSUE = 3'd4,
    ADD_WAIT  = 3'd5,
    WRITE     = 3'd6,
    ERR       = 3'd7
  } muladd_state_t;

  // writeen_sel encodings for the downstream write-enable mux
  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] MULT   = 2'b01;
  localparam logic [1:0] MULADD = 2'b10;

  function automatic logic is_wait_state(input muladd_state_t s);
    return (s == MUL_WAIT) || (s == ADD_WAIT);
  endfunction

endpackage

// File: rtl/muladd_controller_wait_timer.sv
// Bounded wait counter: expired flags the last permitted wait cycle while enabled.
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Keep at least one bit so WAIT_MAX=1 still elaborates.
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/muladd_controller.sv
// Fused multiply-add sequencer: reads operands, launches multiplier then adder,
// and issues a one-cycle write request (or a timeout error) on completion.
//
// Handshakes: mult_start/add_start are single-cycle launches; the matching
// *_done input is honoured only in the corresponding wait state and is ignored
// in every other state, including the issue cycle.
module muladd_controller
  import proc_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] src_c,
  input  logic [ADDR_W-1:0] dst,
  input  logic              mult_done,
  input  logic              add_done,
  output logic [ADDR_W-1:0] rd_addr_0,
  output logic [ADDR_W-1:0] rd_addr_1,
  output logic              mult_start,
  output logic              add_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              writeen_muladd_cont,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  muladd_state_t state, next_state;
  logic [ADDR_W-1:0] a_q, b_q, c_q, dst_q;
  logic              timer_clear, timer_enable, expired;

  assign dbg_state    = state;
  assign timer_enable = is_wait_state(state);
  assign timer_clear  = !is_wait_state(state);

  wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operands are captured only on acceptance, so a start while busy cannot disturb them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      dst_q <= '0;
    end else if (state == IDLE && start) begin
      a_q   <= src_a;
      b_q   <= src_b;
      c_q   <= src_c;
      dst_q <= dst;
    end
  end

  always_comb begin
    next_state          = state;
    rd_addr_0           = '0;
    rd_addr_1           = '0;
    mult_start          = 1'b0;
    add_start           = 1'b0;
    wr_addr             = '0;
    writeen_muladd_cont = 1'b0;
    done                = 1'b0;
    error               = 1'b0;
    busy                = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) next_state = RD_AB;
      end
      RD_AB: begin
        rd_addr_0  = a_q;
        rd_addr_1  = b_q;
        next_state = MUL_ISSUE;
      end
      MUL_ISSUE: begin
        rd_addr_0  = a_q;
        rd_addr_1  = b_q;
        mult_start = 1'b1;
        next_state = MUL_WAIT;
      end
      MUL_WAIT: begin
        rd_addr_0 = a_q;
        rd_addr_1 = b_q;
        // done is checked first so a completion on the last wait cycle wins
        if (mult_done)    next_state = ADD_ISSUE;
        else if (expired) next_state = ERR;
      end
      ADD_ISSUE: begin
        rd_addr_1  = c_q;
        add_start  = 1'b1;
        next_state = ADD_WAIT;
      end
      ADD_WAIT: begin
        rd_addr_1 = c_q;
        if (add_done)     next_state = WRITE;
        else if (expired) next_state = ERR;
      end
      WRITE: begin
        wr_addr             = dst_q;
        writeen_muladd_cont = 1'b1;
        done                = 1'b1;
        next_state          = IDLE;
      end
      ERR: begin
        error      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muladd_controller.sv
// Directed bench for muladd_controller: per-cycle output vectors against a
// timing model of the operation sequence.
module tb_muladd_controller;

  localparam int WM = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] src_a = '0, src_b = '0, src_c = '0, dst = '0;
  logic       mult_done = 1'b0, add_done = 1'b0;
  logic [3:0] rd_addr_0, rd_addr_1, wr_addr;
  logic       mult_start, add_start, writeen_muladd_cont, busy, done, error;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // {rd0, rd1, wr_addr, we, done, busy, mult_start, add_start, error}
  logic [17:0] obs_vec [64];

  muladd_controller #(.ADDR_W(4), .WAIT_MAX(WM)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .src_a               (src_a),
    .src_b               (src_b),
    .src_c               (src_c),
    .dst                 (dst),
    .mult_done           (mult_done),
    .add_done            (add_done),
    .rd_addr_0           (rd_addr_0),
    .rd_addr_1           (rd_addr_1),
    .mult_start          (mult_start),
    .add_start           (add_start),
    .wr_addr             (wr_addr),
    .writeen_muladd_cont (writeen_muladd_cont),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .dbg_state           (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs in cycle k (start sampled at the end of cycle 0).
  // tm: cycle mult_done is taken; ta: cycle add_done is taken, or -1 for a timeout.
  function automatic logic [17:0] exp_vec(input int k, input int tm, input int ta,
                                          input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] d);
    int endc;
    logic [3:0] r0, r1, w;
    logic we, dn, bz, ms, as_, er;
    endc = (ta < 0) ? (tm + 2 + WM) : (ta + 1);
    r0 = '0; r1 = '0; w = '0;
    we = 1'b0; dn = 1'b0; er = 1'b0;
    if (k >= 1 && k <= tm) begin
      r0 = a;
      r1 = b;
    end else if (k > tm && k < endc) begin
      r1 = c;
    end
    if (k == endc && ta >= 0) begin
      we = 1'b1;
      dn = 1'b1;
      w  = d;
    end
    if (k == endc && ta < 0) er = 1'b1;
    bz  = (k >= 1 && k <= endc);
    ms  = (k == 2);
    as_ = (k == tm + 1);
    return {r0, r1, w, we, dn, bz, ms, as_, er};
  endfunction

  // Drives one scenario cycle by cycle; bit k of each mask is the input level during cycle k.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] d2,
                        input logic [63:0] smask, input logic [63:0] mmask,
                        input logic [63:0] amask, input logic [63:0] rmask,
                        input int ncyc);
    src_a = a; src_b = b; src_c = c; dst = d;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) dst = d2;
      start     = smask[k];
      mult_done = mmask[k];
      add_done  = amask[k];
      reset_n   = !rmask[k];
      @(posedge clk);
      #1;
      obs_vec[k+1] = {rd_addr_0, rd_addr_1, wr_addr, writeen_muladd_cont, done,
                      busy, mult_start, add_start, error};
    end
    start = 1'b0; mult_done = 1'b0; add_done = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; mult_done = 1'b1; add_done = 1'b1;
    src_a = 4'hf; dst = 4'ha;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd_addr_0, rd_addr_1, wr_addr, writeen_muladd_cont, done, busy, mult_start,
         add_start, error} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {rd_addr_0, rd_addr_1, wr_addr,
               writeen_muladd_cont, done, busy, mult_start, add_start, error});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    reset_n = 1'b1; start = 1'b0; mult_done = 1'b0; add_done = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release_idle got busy=%b state=%0d exp busy=0 state=0", busy, dbg_state);
    end
  endtask

  task automatic test_nominal();
    run_op(4'd1, 4'd2, 4'd3, 4'd5, 4'd5, 64'h1, 64'h8, 64'h20, 64'h0, 9);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec(k, 3, 5, 4'd1, 4'd2, 4'd3, 4'd5)) begin
        errors++;
        $display("FAIL nominal cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 exp_vec(k, 3, 5, 4'd1, 4'd2, 4'd3, 4'd5));
      end
    end
  endtask

  task automatic test_stalled_mult();
    int ms_cnt;
    run_op(4'd4, 4'd6, 4'd7, 4'd2, 4'd2, 64'h1, 64'h80, 64'h200, 64'h0, 12);
    ms_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      if (obs_vec[k][2]) ms_cnt++;
      checks++;
      if (obs_vec[k] !== exp_vec(k, 7, 9, 4'd4, 4'd6, 4'd7, 4'd2)) begin
        errors++;
        $display("FAIL stalled_mult cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 exp_vec(k, 7, 9, 4'd4, 4'd6, 4'd7, 4'd2));
      end
    end
    checks++;
    if (ms_cnt != 1) begin
      errors++;
      $display("FAIL stalled_mult_start_count got=%0d exp=1", ms_cnt);
    end
  endtask

  // Add stage never completes; a new start in the IDLE cycle right after ERR is accepted.
  task automatic test_timeout();
    int we_cnt;
    run_op(4'd8, 4'd9, 4'd10, 4'd11, 4'd11, (64'd1 | (64'd1 << 21)),
           ((64'd1 << 3) | (64'd1 << 24)), (64'd1 << 26), 64'h0, 29);
    we_cnt = 0;
    for (int k = 1; k <= 21; k++) begin
      if (obs_vec[k][5]) we_cnt++;
      checks++;
      if (obs_vec[k] !== exp_vec(k, 3, -1, 4'd8, 4'd9, 4'd10, 4'd11)) begin
        errors++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 exp_vec(k, 3, -1, 4'd8, 4'd9, 4'd10, 4'd11));
      end
    end
    checks++;
    if (we_cnt != 0) begin
      errors++;
      $display("FAIL timeout_no_write got=%0d write pulses exp=0", we_cnt);
    end
    for (int k = 22; k <= 29; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec(k - 21, 3, 5, 4'd8, 4'd9, 4'd10, 4'd11)) begin
        errors++;
        $display("FAIL start_after_err cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 exp_vec(k - 21, 3, 5, 4'd8, 4'd9, 4'd10, 4'd11));
      end
    end
  endtask

  task automatic test_collision();
    run_op(4'd3, 4'd5, 4'd7, 4'd12, 4'd12, 64'h1, (64'd1 << 3), (64'd1 << 19), 64'h0, 22);
    for (int k = 1; k <= 22; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec(k, 3, 19, 4'd3, 4'd5, 4'd7, 4'd12)) begin
        errors++;
        $display("FAIL collision cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 exp_vec(k, 3, 19, 4'd3, 4'd5, 4'd7, 4'd12));
      end
    end
  endtask

  task automatic test_ignored_start();
    run_op(4'd1, 4'd2, 4'd3, 4'd5, 4'd9, ((64'd1) | (64'd1 << 3)), (64'd1 << 3),
           (64'd1 << 5), 64'h0, 10);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec(k, 3, 5, 4'd1, 4'd2, 4'd3, 4'd5)) begin
        errors++;
        $display("FAIL ignored_start cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 exp_vec(k, 3, 5, 4'd1, 4'd2, 4'd3, 4'd5));
      end
    end
  endtask

  // Done pulses in the issue cycles and in the wrong wait state must be ignored.
  task automatic test_stray_done();
    run_op(4'd2, 4'd4, 4'd6, 4'd14, 4'd14, 64'h1, ((64'd1 << 2) | (64'd1 << 4)),
           ((64'd1 << 3) | (64'd1 << 4) | (64'd1 << 5) | (64'd1 << 7)), 64'h0, 10);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec(k, 4, 7, 4'd2, 4'd4, 4'd6, 4'd14)) begin
        errors++;
        $display("FAIL stray_done cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 exp_vec(k, 4, 7, 4'd2, 4'd4, 4'd6, 4'd14));
      end
    end
  endtask

  task automatic test_reset_mid();
    run_op(4'd1, 4'd2, 4'd3, 4'd5, 4'd5, 64'h1, (64'd1 << 3), (64'd1 << 5), (64'd1 << 4), 9);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (obs_vec[k] !== ((k <= 4) ? exp_vec(k, 3, 5, 4'd1, 4'd2, 4'd3, 4'd5) : 18'h0)) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 ((k <= 4) ? exp_vec(k, 3, 5, 4'd1, 4'd2, 4'd3, 4'd5) : 18'h0));
      end
    end
    run_op(4'd6, 4'd7, 4'd8, 4'd13, 4'd13, 64'h1, (64'd1 << 3), (64'd1 << 5), 64'h0, 8);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec(k, 3, 5, 4'd6, 4'd7, 4'd8, 4'd13)) begin
        errors++;
        $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 exp_vec(k, 3, 5, 4'd6, 4'd7, 4'd8, 4'd13));
      end
    end
  endtask

  // Second start arrives in the single IDLE cycle that follows WRITE.
  task automatic test_back_to_back();
    run_op(4'd9, 4'd10, 4'd11, 4'd15, 4'd15, ((64'd1) | (64'd1 << 7)),
           ((64'd1 << 3) | (64'd1 << 10)), ((64'd1 << 5) | (64'd1 << 12)), 64'h0, 15);
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if (obs_vec[k] !== ((k <= 7) ? exp_vec(k, 3, 5, 4'd9, 4'd10, 4'd11, 4'd15)
                                   : exp_vec(k - 7, 3, 5, 4'd9, 4'd10, 4'd11, 4'd15))) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", k, obs_vec[k],
                 ((k <= 7) ? exp_vec(k, 3, 5, 4'd9, 4'd10, 4'd11, 4'd15)
                           : exp_vec(k - 7, 3, 5, 4'd9, 4'd10, 4'd11, 4'd15)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stalled_mult();
    test_timeout();
    test_collision();
    test_ignored_start();
    test_stray_done();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
